// File: rtl/tinuc_dmem_arbiter.sv
// tinuc_dmem_arbiter: shares the single-port data RAM between the TinuC MEM
// stage (default priority) and an external requester. A starvation counter
// forces one external grant after MAX_WAIT consecutive lost cycles, stalling
// the core for that one cycle.
module tinuc_dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32
) (
  input  logic          CLK,
  input  logic          RESET_N,
  // core MEM-stage port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  // external requester port
  input  logic          e_valid,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_ready,
  output logic          e_rvalid,
  output logic [DW-1:0] e_rdata,
  // RAM port
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } st_t;

  st_t           st;
  st_t           st_nxt;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] wcnt_nxt;
  logic          gnt_c;
  logic          gnt_e;
  logic          lost;
  logic          e_rd_gnt;

  // State and starvation counter registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      st   <= ST_NORMAL;
      wcnt <= '0;
    end else begin
      st   <= st_nxt;
      wcnt <= wcnt_nxt;
    end
  end

  // Grant decision, lost-cycle counting and next state
  always_comb begin
    gnt_c    = 1'b0;
    gnt_e    = 1'b0;
    lost     = 1'b0;
    wcnt_nxt = '0;
    st_nxt   = ST_NORMAL;
    if (RESET_N) begin
      unique case (st)
        ST_FORCE: begin
          gnt_e = e_valid;
          gnt_c = c_req & ~e_valid;
        end
        default: begin
          gnt_c = c_req;
          gnt_e = e_valid & ~c_req;
        end
      endcase
    end
    lost = e_valid & ~gnt_e;
    if (lost) begin
      wcnt_nxt = (wcnt >= WAIT_MAX) ? WAIT_MAX : wcnt + CW'(1);
    end
    // FORCE always lasts exactly one cycle, so only NORMAL can enter it
    if ((st == ST_NORMAL) && lost && (wcnt == WAIT_LAST)) begin
      st_nxt = ST_FORCE;
    end
  end

  // RAM mux and combinational handshake outputs
  always_comb begin
    m_addr   = '0;
    m_we     = 1'b0;
    m_wdata  = '0;
    c_rdata  = '0;
    e_ready  = gnt_e;
    e_rd_gnt = gnt_e & ~e_we;
    c_stall  = RESET_N & (st == ST_FORCE) & e_valid & c_req;
    if (gnt_c) begin
      m_addr  = c_addr;
      m_we    = c_we;
      m_wdata = c_wdata;
      c_rdata = m_rdata;
    end else if (gnt_e) begin
      m_addr  = e_addr;
      m_we    = e_we;
      m_wdata = e_wdata;
    end
  end

  // External read response, one cycle after the read grant
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      e_rvalid <= 1'b0;
      e_rdata  <= '0;
    end else begin
      e_rvalid <= e_rd_gnt;
      if (e_rd_gnt) begin
        e_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_tinuc_dmem_arbiter.sv
// Bench for tinuc_dmem_arbiter: directed vectors with literal checks plus a
// per-cycle comparison against a lost-run based behavioural model.
module tb_tinuc_dmem_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          c_req, c_we, e_valid, e_we;
  logic [AW-1:0] c_addr, e_addr;
  logic [DW-1:0] c_wdata, e_wdata;
  logic [DW-1:0] c_rdata, e_rdata, m_wdata, m_rdata;
  logic          c_stall, e_ready, e_rvalid, m_we;
  logic [AW-1:0] m_addr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always #5 CLK = ~CLK;

  tinuc_dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .e_valid(e_valid), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_ready(e_ready), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // RAM environment: asynchronous read, write on the clock edge
  assign m_rdata = ram[m_addr];
  always @(posedge CLK) begin
    if (m_we === 1'b1) ram[m_addr] <= m_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the external side is forced once it has lost MAX_WAIT cycles in a row
  int unsigned   run;
  logic          mdl_rv;
  logic [DW-1:0] mdl_rd;
  logic          forced, x_gnt_e, x_gnt_c;
  assign forced  = (run == MAX_WAIT);
  assign x_gnt_e = RESET_N & e_valid & (forced | ~c_req);
  assign x_gnt_c = RESET_N & c_req & ~x_gnt_e;

  always @(posedge CLK) begin
    if (!RESET_N) begin
      run    <= 0;
      mdl_rv <= 1'b0;
      mdl_rd <= '0;
    end else begin
      run    <= (e_valid && !x_gnt_e) ? run + 1 : 0;
      mdl_rv <= x_gnt_e & ~e_we;
      if (x_gnt_e && !e_we) mdl_rd <= ram[e_addr];
    end
  end

  // Compare all outputs against the model every cycle
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_e_ready", 64'(e_ready), 64'(x_gnt_e));
      chk("m_c_stall", 64'(c_stall), 64'(RESET_N & forced & e_valid & c_req));
      chk("m_we", 64'(m_we), 64'(x_gnt_c ? c_we : (x_gnt_e ? e_we : 1'b0)));
      chk("m_c_rdata", 64'(c_rdata), x_gnt_c ? 64'(ram[c_addr]) : 64'd0);
      chk("m_e_rvalid", 64'(e_rvalid), 64'(mdl_rv));
      chk("m_e_rdata", 64'(e_rdata), 64'(mdl_rd));
      if (RESET_N) begin
        chk("m_addr", 64'(m_addr), x_gnt_c ? 64'(c_addr) : (x_gnt_e ? 64'(e_addr) : 64'd0));
        chk("m_wdata", 64'(m_wdata), x_gnt_c ? 64'(c_wdata) : (x_gnt_e ? 64'(e_wdata) : 64'd0));
      end
    end
  end

  task automatic drive(input logic rn, input logic cr, input logic cw,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic ev, input logic ew,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    RESET_N = rn; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    e_valid = ev; e_we = ew; e_addr = ea; e_wdata = ed;
  endtask

  task automatic to_sample();
    @(negedge CLK);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    // Reset held two cycles with both requesters active
    drive(1'b0, 1'b1, 1'b1, 10'h005, 32'h1111_1111, 1'b1, 1'b1, 10'h006, 32'h2222_2222);
    next_cycle();
    chk_en = 1'b1;
    to_sample();
    chk("rst_m_we", 64'(m_we), 64'd0);
    chk("rst_e_ready", 64'(e_ready), 64'd0);
    chk("rst_c_stall", 64'(c_stall), 64'd0);
    chk("rst_e_rvalid", 64'(e_rvalid), 64'd0);
    chk("rst_c_rdata", 64'(c_rdata), 64'd0);
    next_cycle();

    // First cycle after release: core wins
    drive(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 1'b1, 1'b0, 10'h006, 32'h0);
    to_sample();
    chk("rel_e_ready", 64'(e_ready), 64'd0);
    chk("rel_m_addr", 64'(m_addr), 64'h005);
    next_cycle();

    // Idle core: external write then read of 0x010
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF);
    to_sample();
    chk("idle_wr_ready", 64'(e_ready), 64'd1);
    chk("idle_wr_m_we", 64'(m_we), 64'd1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 10'h010, 32'h0);
    to_sample();
    chk("idle_rd_ready", 64'(e_ready), 64'd1);
    chk("idle_rd_stall", 64'(c_stall), 64'd0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    to_sample();
    chk("idle_rvalid", 64'(e_rvalid), 64'd1);
    chk("idle_rdata", 64'(e_rdata), 64'hDEAD_BEEF);
    next_cycle();
    to_sample();
    chk("idle_rvalid_drop", 64'(e_rvalid), 64'd0);
    next_cycle();

    // Starvation under continuous core requests
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(1'b1, 1'b1, 1'b0, 10'h030, 32'h0, 1'b1, 1'b0, 10'h010, 32'h0);
      to_sample();
      chk("starve_ready", 64'(e_ready), (cyc == 4) ? 64'd1 : 64'd0);
      chk("starve_stall", 64'(c_stall), (cyc == 4) ? 64'd1 : 64'd0);
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 10'h030, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    to_sample();
    chk("starve_rvalid", 64'(e_rvalid), 64'd1);
    chk("starve_rdata", 64'(e_rdata), 64'hDEAD_BEEF);
    chk("starve_stall_after", 64'(c_stall), 64'd0);
    next_cycle();

    // Core priority: core writes 0x020 in cycles 0-1, external read of 0x020 pending
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive(1'b1, (cyc < 2), 1'b1, 10'h020, 32'h1234_5678, 1'b1, 1'b0, 10'h020, 32'h0);
      to_sample();
      chk("prio_ready", 64'(e_ready), (cyc == 2) ? 64'd1 : 64'd0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    to_sample();
    chk("prio_rvalid", 64'(e_rvalid), 64'd1);
    chk("prio_rdata", 64'(e_rdata), 64'h1234_5678);
    next_cycle();

    // Dropped request clears the counter: 3 lost, drop, 3 lost, never stalls
    for (int cyc = 0; cyc < 9; cyc++) begin
      drive(1'b1, 1'b1, 1'b0, 10'h040, 32'h0, (cyc < 3) || (cyc > 5), 1'b0, 10'h050, 32'h0);
      to_sample();
      chk("drop_stall", 64'(c_stall), 64'd0);
      chk("drop_ready", 64'(e_ready), 64'd0);
      next_cycle();
    end

    // Reset abandons a pending FORCE and drops e_rdata
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(1'b1, 1'b1, 1'b0, 10'h040, 32'h0, 1'b1, 1'b0, 10'h020, 32'h0);
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 10'h040, 32'h0, 1'b1, 1'b0, 10'h020, 32'h0);
    to_sample();
    chk("rstf_stall", 64'(c_stall), 64'd0);
    chk("rstf_ready", 64'(e_ready), 64'd0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 10'h040, 32'h0, 1'b1, 1'b0, 10'h020, 32'h0);
    to_sample();
    chk("rstf_normal_ready", 64'(e_ready), 64'd0);
    chk("rstf_normal_stall", 64'(c_stall), 64'd0);
    chk("rstf_rdata", 64'(e_rdata), 64'd0);
    next_cycle();

    // Reset in the cycle an idle-core read would be granted
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 10'h010, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    to_sample();
    chk("rstrd_rvalid", 64'(e_rvalid), 64'd0);
    chk("rstrd_rdata", 64'(e_rdata), 64'd0);
    next_cycle();

    // Mixed patterns checked by the model only
    for (int i = 0; i < 120; i++) begin
      drive(1'b1, (i % 5) != 0, (i % 3) == 0, AW'(i % 16), DW'(32'hA000_0000 + i),
            (i % 7) != 3, (i % 4) == 1, AW'((i * 3) % 16), DW'(32'hB000_0000 + i));
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
